// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between I-cache refills and the D-cache,
// tracks tag ownership and routes responses. Optional anti-starvation: MEM_ARB_ANTI_STARVE_EN.
module mem_bus_arbiter #(
`ifdef MEM_ARB_ANTI_STARVE_EN
    parameter int unsigned STARVE_LIMIT = 4,
`endif
    parameter int unsigned MAX_I_OUT    = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        icache_req_valid,
    input  logic [31:0] icache_req_addr,
    output logic        icache_req_accepted,
    output logic        icache_resp_valid,
    output logic [3:0]  icache_resp_tag,
    output logic [63:0] icache_resp_data,

    input  logic        dcache_req_valid,
    input  logic [1:0]  dcache_req_cmd,
    input  logic [31:0] dcache_req_addr,
    input  logic [63:0] dcache_req_data,
    output logic        dcache_req_accepted,
    output logic [3:0]  dcache_req_tag,
    output logic        dcache_resp_valid,
    output logic [3:0]  dcache_resp_tag,
    output logic [63:0] dcache_resp_data,

    input  logic        restore_valid,

    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    input  logic [3:0]  mem2proc_transaction_tag,
    input  logic [3:0]  mem2proc_data_tag,
    input  logic [63:0] mem2proc_data,

    output logic [2:0]  i_outstanding
);

    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;
    localparam logic [3:0] L_MAX_I  = 4'(MAX_I_OUT);

    logic [15:0] r_valid;
    logic [15:0] r_own_i;
    logic [15:0] r_drop;
    logic [2:0]  r_i_out;

    logic [15:0] w_valid_nxt;
    logic [15:0] w_own_nxt;
    logic [15:0] w_drop_nxt;

    logic        w_i_elig;
    logic        w_force_i;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_tag_ok;
    logic        w_acc_d;
    logic        w_acc_i;
    logic        w_alloc;
    logic        w_hit;

    assign w_i_elig  = icache_req_valid && !restore_valid
                       && ({1'b0, r_i_out} < L_MAX_I) && !reset;
    assign w_grant_d = dcache_req_valid && !reset && !w_force_i;
    assign w_grant_i = w_i_elig && !w_grant_d;
    assign w_tag_ok  = |mem2proc_transaction_tag;
    assign w_acc_d   = w_grant_d && w_tag_ok;
    assign w_acc_i   = w_grant_i && w_tag_ok;
    assign w_alloc   = (w_acc_d && (dcache_req_cmd == MEM_LOAD)) || w_acc_i;

`ifdef MEM_ARB_ANTI_STARVE_EN
    localparam logic [7:0] L_STARVE = 8'(STARVE_LIMIT);
    logic [7:0] r_starve;

    assign w_force_i = (r_starve >= L_STARVE) && w_i_elig;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (!icache_req_valid || w_acc_i) begin
            r_starve <= '0;
        end else if (w_i_elig && (r_starve < L_STARVE)) begin
            r_starve <= r_starve + 8'd1;
        end
    end
`else
    assign w_force_i = 1'b0;
`endif

    always_comb begin
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (w_grant_d) begin
            proc2mem_command = dcache_req_cmd;
            proc2mem_addr    = dcache_req_addr;
            proc2mem_data    = dcache_req_data;
        end else if (w_grant_i) begin
            proc2mem_command = MEM_LOAD;
            proc2mem_addr    = icache_req_addr;
        end
    end

    assign icache_req_accepted = w_acc_i;
    assign dcache_req_accepted = w_acc_d;
    assign dcache_req_tag      = w_acc_d ? mem2proc_transaction_tag : '0;

    assign w_hit             = (|mem2proc_data_tag) && r_valid[mem2proc_data_tag] && !reset;
    assign dcache_resp_valid = w_hit && !r_own_i[mem2proc_data_tag];
    assign icache_resp_valid = w_hit && r_own_i[mem2proc_data_tag] && !r_drop[mem2proc_data_tag];
    assign icache_resp_tag   = mem2proc_data_tag;
    assign dcache_resp_tag   = mem2proc_data_tag;
    assign icache_resp_data  = mem2proc_data;
    assign dcache_resp_data  = mem2proc_data;
    assign i_outstanding     = r_i_out;

    // Free, then drop, then allocate: a tag freed and re-issued in one cycle ends up owned by the new requester.
    always_comb begin
        w_valid_nxt = r_valid;
        w_own_nxt   = r_own_i;
        w_drop_nxt  = r_drop;
        if (w_hit) begin
            w_valid_nxt[mem2proc_data_tag] = 1'b0;
        end
        if (restore_valid) begin
            w_drop_nxt = r_drop | (r_valid & r_own_i);
        end
        if (w_alloc) begin
            w_valid_nxt[mem2proc_transaction_tag] = 1'b1;
            w_own_nxt[mem2proc_transaction_tag]   = w_acc_i;
            w_drop_nxt[mem2proc_transaction_tag]  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_own_i <= '0;
            r_drop  <= '0;
            r_i_out <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_own_i <= w_own_nxt;
            r_drop  <= w_drop_nxt;
            if (restore_valid) begin
                r_i_out <= '0;
            end else if (w_acc_i && !icache_resp_valid) begin
                r_i_out <= r_i_out + 3'd1;
            end else if (!w_acc_i && icache_resp_valid) begin
                r_i_out <= r_i_out - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a tag-ownership model.
module tb_mem_bus_arbiter;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_LOAD  = 2'd1;
    localparam logic [1:0] C_STORE = 2'd2;
    localparam int LIMIT = 4;
    localparam int MAXI  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_accepted;
    logic        icache_resp_valid;
    logic [3:0]  icache_resp_tag;
    logic [63:0] icache_resp_data;
    logic        dcache_req_valid;
    logic [1:0]  dcache_req_cmd;
    logic [31:0] dcache_req_addr;
    logic [63:0] dcache_req_data;
    logic        dcache_req_accepted;
    logic [3:0]  dcache_req_tag;
    logic        dcache_resp_valid;
    logic [3:0]  dcache_resp_tag;
    logic [63:0] dcache_resp_data;
    logic        restore_valid;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_transaction_tag;
    logic [3:0]  mem2proc_data_tag;
    logic [63:0] mem2proc_data;
    logic [2:0]  i_outstanding;

    mem_bus_arbiter #(
`ifdef MEM_ARB_ANTI_STARVE_EN
        .STARVE_LIMIT(LIMIT),
`endif
        .MAX_I_OUT(MAXI)
    ) dut (
        .clock(clock), .reset(reset),
        .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
        .icache_req_accepted(icache_req_accepted), .icache_resp_valid(icache_resp_valid),
        .icache_resp_tag(icache_resp_tag), .icache_resp_data(icache_resp_data),
        .dcache_req_valid(dcache_req_valid), .dcache_req_cmd(dcache_req_cmd),
        .dcache_req_addr(dcache_req_addr), .dcache_req_data(dcache_req_data),
        .dcache_req_accepted(dcache_req_accepted), .dcache_req_tag(dcache_req_tag),
        .dcache_resp_valid(dcache_resp_valid), .dcache_resp_tag(dcache_resp_tag),
        .dcache_resp_data(dcache_resp_data), .restore_valid(restore_valid),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_transaction_tag(mem2proc_transaction_tag),
        .mem2proc_data_tag(mem2proc_data_tag), .mem2proc_data(mem2proc_data),
        .i_outstanding(i_outstanding)
    );

    always #5 clock = ~clock;

    // Model: per tag 0=free, 1=D-owned, 2=I-owned live, 3=I-owned dropped.
    int mtab[16];
    int ntab[16];
    int mstarve;
    int nstarve;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [1:0]  dc;
        logic [31:0] da;
        logic [3:0]  tt;
        logic [3:0]  dt;
        logic [1:0]  e_cmd;
        logic        e_iacc;
        logic        e_dacc;
        logic [3:0]  e_dtag;
        logic        e_iresp;
        logic        e_dresp;
        logic [2:0]  e_iout;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic iv, input logic [31:0] ia, input logic dv,
                          input logic [1:0] dc, input logic [31:0] da,
                          input logic [3:0] tt, input logic [3:0] dt,
                          input logic rs, input logic rsv);
        icache_req_valid         = iv;
        icache_req_addr          = ia;
        dcache_req_valid         = dv;
        dcache_req_cmd           = dc;
        dcache_req_addr          = da;
        dcache_req_data          = {$urandom, $urandom};
        mem2proc_transaction_tag = tt;
        mem2proc_data_tag        = dt;
        mem2proc_data            = {$urandom, $urandom};
        reset                    = rs;
        restore_valid            = rsv;
    endtask

    // Waits to mid-cycle, compares every output with the model, and prepares the model's next state.
    task automatic settle_check();
        int          iout;
        bit          ielig, force_i, dwin, iwin, dacc, iacc, hit;
        logic [1:0]  ecmd;
        logic [31:0] eaddr;
        logic [63:0] edata;
        int          owner;
        #4;
        if (reset) begin
            for (int k = 0; k < 16; k++) mtab[k] = 0;
            mstarve = 0;
        end
        iout = 0;
        for (int k = 1; k < 16; k++) if (mtab[k] == 2) iout++;
        ielig = icache_req_valid && !restore_valid && (iout < MAXI) && !reset;
`ifdef MEM_ARB_ANTI_STARVE_EN
        force_i = (mstarve >= LIMIT) && ielig;
`else
        force_i = 1'b0;
`endif
        dwin = dcache_req_valid && !reset && !force_i;
        iwin = ielig && !dwin;
        dacc = dwin && (mem2proc_transaction_tag != 4'd0);
        iacc = iwin && (mem2proc_transaction_tag != 4'd0);
        ecmd = dwin ? dcache_req_cmd : (iwin ? C_LOAD : C_NONE);
        eaddr = dwin ? dcache_req_addr : (iwin ? icache_req_addr : 32'd0);
        edata = dwin ? dcache_req_data : 64'd0;
        owner = mtab[mem2proc_data_tag];
        hit = (mem2proc_data_tag != 4'd0) && (owner != 0) && !reset;

        chk("cmd",      64'(proc2mem_command),    64'(ecmd));
        chk("addr",     64'(proc2mem_addr),       64'(eaddr));
        chk("wdata",    proc2mem_data,            edata);
        chk("i_acc",    64'(icache_req_accepted), 64'(iacc));
        chk("d_acc",    64'(dcache_req_accepted), 64'(dacc));
        chk("d_tag",    64'(dcache_req_tag),      dacc ? 64'(mem2proc_transaction_tag) : 64'd0);
        chk("i_resp",   64'(icache_resp_valid),   64'(hit && owner == 2));
        chk("d_resp",   64'(dcache_resp_valid),   64'(hit && owner == 1));
        chk("i_rtag",   64'(icache_resp_tag),     64'(mem2proc_data_tag));
        chk("d_rtag",   64'(dcache_resp_tag),     64'(mem2proc_data_tag));
        chk("i_rdata",  icache_resp_data,         mem2proc_data);
        chk("d_rdata",  dcache_resp_data,         mem2proc_data);
        chk("i_out",    64'(i_outstanding),       64'(iout));

        for (int k = 0; k < 16; k++) ntab[k] = mtab[k];
        nstarve = mstarve;
        if (!reset) begin
            if (hit) ntab[mem2proc_data_tag] = 0;
            if (restore_valid)
                for (int k = 1; k < 16; k++) if (ntab[k] == 2) ntab[k] = 3;
            if (dacc && dcache_req_cmd == C_LOAD) ntab[mem2proc_transaction_tag] = 1;
            if (iacc) ntab[mem2proc_transaction_tag] = 2;
            if (!icache_req_valid || iacc) nstarve = 0;
            else if (ielig && mstarve < LIMIT) nstarve = mstarve + 1;
        end
    endtask

    task automatic advance();
        for (int k = 0; k < 16; k++) mtab[k] = ntab[k];
        mstarve = nstarve;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        set_in(1'b0, 32'd0, 1'b0, C_NONE, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        set_in(1'b0, 32'd0, 1'b0, C_NONE, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        settle_check();
        chk("rst_cmd",  64'(proc2mem_command), 64'(C_NONE));
        chk("rst_iout", 64'(i_outstanding),    64'd0);
        advance();
        idle_in();
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h100, 1'b1, C_LOAD, 32'h200, 4'd3, 4'd0, C_LOAD, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{1'b1, 32'h100, 1'b0, C_NONE, 32'h0,   4'd4, 4'd0, C_LOAD, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0};
        vecs[2] = '{1'b0, 32'h0,   1'b0, C_NONE, 32'h0,   4'd0, 4'd4, C_NONE, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd1};
        vecs[3] = '{1'b0, 32'h0,   1'b0, C_NONE, 32'h0,   4'd0, 4'd3, C_NONE, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0};
        vecs[4] = '{1'b0, 32'h0,   1'b1, C_LOAD, 32'h240, 4'd0, 4'd0, C_LOAD, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0};
        vecs[5] = '{1'b1, 32'h180, 1'b0, C_NONE, 32'h0,   4'd2, 4'd0, C_LOAD, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0};
        vecs[6] = '{1'b0, 32'h0,   1'b1, C_LOAD, 32'h280, 4'd2, 4'd2, C_LOAD, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 3'd1};
        vecs[7] = '{1'b0, 32'h0,   1'b0, C_NONE, 32'h0,   4'd0, 4'd2, C_NONE, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0};
        vecs[8] = '{1'b0, 32'h0,   1'b0, C_NONE, 32'h0,   4'd0, 4'd2, C_NONE, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0};

        for (int k = 0; k < 16; k++) begin mtab[k] = 0; ntab[k] = 0; end
        mstarve = 0;
        nstarve = 0;
        set_in(1'b0, 32'd0, 1'b0, C_NONE, 32'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        do_reset();

        // Alternating loads, reject and same-cycle tag reuse.
        for (int v = 0; v < 9; v++) begin
            set_in(vecs[v].iv, vecs[v].ia, vecs[v].dv, vecs[v].dc, vecs[v].da,
                   vecs[v].tt, vecs[v].dt, 1'b0, 1'b0);
            settle_check();
            chk("vec_cmd",   64'(proc2mem_command),    64'(vecs[v].e_cmd));
            chk("vec_iacc",  64'(icache_req_accepted), 64'(vecs[v].e_iacc));
            chk("vec_dacc",  64'(dcache_req_accepted), 64'(vecs[v].e_dacc));
            chk("vec_dtag",  64'(dcache_req_tag),      64'(vecs[v].e_dtag));
            chk("vec_iresp", 64'(icache_resp_valid),   64'(vecs[v].e_iresp));
            chk("vec_dresp", 64'(dcache_resp_valid),   64'(vecs[v].e_dresp));
            chk("vec_iout",  64'(i_outstanding),       64'(vecs[v].e_iout));
            advance();
        end

        // Starvation: both requesters busy every cycle.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_in(1'b1, 32'h300, 1'b1, C_LOAD, 32'h400 + 32'(c * 64), 4'(c + 1), 4'd0, 1'b0, 1'b0);
            settle_check();
`ifdef MEM_ARB_ANTI_STARVE_EN
            chk("starve_iacc", 64'(icache_req_accepted), 64'(c == 4));
            chk("starve_dacc", 64'(dcache_req_accepted), 64'(c != 4));
`else
            chk("starve_iacc", 64'(icache_req_accepted), 64'd0);
            chk("starve_dacc", 64'(dcache_req_accepted), 64'd1);
`endif
            advance();
        end

        // Restore drops an in-flight I fill; the tag is reusable afterwards.
        do_reset();
        set_in(1'b1, 32'h500, 1'b0, C_NONE, 32'd0, 4'd5, 4'd0, 1'b0, 1'b0);
        settle_check();
        chk("drop_acc", 64'(icache_req_accepted), 64'd1);
        advance();
        set_in(1'b0, 32'd0, 1'b0, C_NONE, 32'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        settle_check();
        chk("drop_iout_pre", 64'(i_outstanding), 64'd1);
        advance();
        for (int c = 0; c < 10; c++) begin
            idle_in();
            settle_check();
            chk("drop_iout", 64'(i_outstanding), 64'd0);
            advance();
        end
        set_in(1'b0, 32'd0, 1'b0, C_NONE, 32'd0, 4'd0, 4'd5, 1'b0, 1'b0);
        settle_check();
        chk("drop_iresp", 64'(icache_resp_valid), 64'd0);
        chk("drop_dresp", 64'(dcache_resp_valid), 64'd0);
        advance();
        set_in(1'b1, 32'h540, 1'b0, C_NONE, 32'd0, 4'd5, 4'd0, 1'b0, 1'b0);
        settle_check();
        chk("reuse_acc", 64'(icache_req_accepted), 64'd1);
        advance();
        set_in(1'b0, 32'd0, 1'b0, C_NONE, 32'd0, 4'd0, 4'd5, 1'b0, 1'b0);
        settle_check();
        chk("reuse_iresp", 64'(icache_resp_valid), 64'd1);
        advance();

        // Outstanding cap: fifth I load waits for a returning fill.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_in(1'b1, 32'h600 + 32'(c * 64), 1'b0, C_NONE, 32'd0, 4'(c + 1), 4'd0, 1'b0, 1'b0);
            settle_check();
            chk("cap_acc", 64'(icache_req_accepted), 64'd1);
            advance();
        end
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, 32'h700, 1'b0, C_NONE, 32'd0, 4'd6, 4'd0, 1'b0, 1'b0);
            settle_check();
            chk("cap_cmd",  64'(proc2mem_command), 64'(C_NONE));
            chk("cap_iout", 64'(i_outstanding),    64'd4);
            advance();
        end
        set_in(1'b1, 32'h700, 1'b0, C_NONE, 32'd0, 4'd6, 4'd1, 1'b0, 1'b0);
        settle_check();
        chk("cap_cmd_ret", 64'(proc2mem_command),  64'(C_NONE));
        chk("cap_iresp",   64'(icache_resp_valid), 64'd1);
        advance();
        set_in(1'b1, 32'h700, 1'b0, C_NONE, 32'd0, 4'd6, 4'd0, 1'b0, 1'b0);
        settle_check();
        chk("cap_acc5",  64'(icache_req_accepted), 64'd1);
        chk("cap_addr5", 64'(proc2mem_addr),       64'h700);
        advance();

        // Async reset between edges with three loads outstanding.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, 32'h800 + 32'(c * 64), 1'b0, C_NONE, 32'd0, 4'(c + 1), 4'd0, 1'b0, 1'b0);
            settle_check();
            advance();
        end
        set_in(1'b1, 32'h900, 1'b1, C_LOAD, 32'hA00, 4'd7, 4'd1, 1'b1, 1'b0);
        settle_check();
        chk("arst_cmd",   64'(proc2mem_command),    64'(C_NONE));
        chk("arst_iacc",  64'(icache_req_accepted), 64'd0);
        chk("arst_dacc",  64'(dcache_req_accepted), 64'd0);
        chk("arst_iout",  64'(i_outstanding),       64'd0);
        chk("arst_iresp", 64'(icache_resp_valid),   64'd0);
        advance();
        set_in(1'b0, 32'd0, 1'b0, C_NONE, 32'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        settle_check();
        chk("orphan_iresp", 64'(icache_resp_valid), 64'd0);
        advance();

        // Randomized traffic; memory only issues tags that are free or being freed this cycle.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [3:0] dt;
            logic [3:0] tt;
            int         t;
            dt = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            t  = $urandom_range(1, 15);
            if ((mtab[t] != 0 && 4'(t) != dt) || ($urandom % 8 == 0)) tt = 4'd0;
            else tt = 4'(t);
            set_in(1'($urandom % 2), {$urandom} & 32'hFFFF_FFC0, 1'($urandom % 2),
                   ($urandom % 2 == 0) ? C_LOAD : C_STORE, {$urandom} & 32'hFFFF_FFC0,
                   tt, dt, ($urandom % 100 == 0), ($urandom % 20 == 0));
            settle_check();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
